// File: rtl/stg_if.sv
// Instruction-fetch stage: captures {pc, instr} from the address stage and
// memory into a small first-word-fall-through queue so decode can stall
// without losing fetches already in flight. Raises an early stall to the PC
// generator, keeps a sticky overflow flag, and honours pipeline flush.

`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module stg_if #(
    parameter int DEPTH      = 4,   // power of two, >= 2
    parameter int AFULL_FREE = 2    // < DEPTH
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst,
    input  logic [`SIZE_ADDR-1:0] iw_pc,
    input  logic                  iw_ia_valid,
    input  logic [`SIZE_DATA-1:0] iw_mem_data,
    input  logic                  iw_flush,
    input  logic                  iw_id_ready,
    output logic [`SIZE_ADDR-1:0] ow_pc,
    output logic [`SIZE_DATA-1:0] ow_instr,
    output logic                  ow_if_valid,
    output logic                  ow_stall,
    output logic                  ow_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFREE_C = CW'(AFULL_FREE);

    // Entry storage; contents are only observed through count, so no reset.
    logic [`SIZE_ADDR-1:0] pc_mem_q    [DEPTH];
    logic [`SIZE_DATA-1:0] instr_mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overflow_q, overflow_d;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic wr_en;

    // Handshake decode and next-state for pointers, count and overflow.
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == DEPTH_C);
        pop        = ~empty & iw_id_ready;
        // A full queue still accepts a fetch when the head leaves this cycle.
        push       = iw_ia_valid & (~full | pop);
        wr_en      = push & ~iw_flush & iw_rst;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (iw_flush) begin
            // Flush discards everything, including this cycle's fetch, and
            // deliberately leaves the sticky overflow alone.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            if (push)
                wr_ptr_d = wr_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
            if (iw_ia_valid & full & ~pop)
                overflow_d = 1'b1;
        end
    end

    // Control state with synchronous active-low reset overriding everything.
    always_ff @(posedge iw_clk) begin
        if (!iw_rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry write at the write pointer.
    always_ff @(posedge iw_clk) begin
        if (wr_en) begin
            pc_mem_q[wr_ptr_q]    <= iw_pc;
            instr_mem_q[wr_ptr_q] <= iw_mem_data;
        end
    end

    // Fall-through head view, zeroed when empty; stall from registered count.
    always_comb begin
        ow_if_valid = ~empty;
        ow_pc       = empty ? '0 : pc_mem_q[rd_ptr_q];
        ow_instr    = empty ? '0 : instr_mem_q[rd_ptr_q];
        ow_stall    = (DEPTH_C - count_q) <= AFREE_C;
        ow_overflow = overflow_q;
    end

endmodule
